// File: rtl/deserializer_if.sv
// Serial-in / word-out bundle for the deserializer.
// master: bit source and word consumer; slave: the deserializer.
interface deserializer_if #(
  parameter int unsigned L = 128
) ();
  logic         qbit;
  logic         qbiten;
  logic [L-1:0] q;
  logic         qvalid;
  logic         qready;
  logic         overrun;
  logic [7:0]   dropped;
  logic         frame_err;

  modport master (
    output qbit,
    output qbiten,
    output qready,
    input  q,
    input  qvalid,
    input  overrun,
    input  dropped,
    input  frame_err
  );

  modport slave (
    input  qbit,
    input  qbiten,
    input  qready,
    output q,
    output qvalid,
    output overrun,
    output dropped,
    output frame_err
  );
endinterface

// File: rtl/deserializer.sv
// Collects an MSB-first bit stream into L-bit words on a one-deep valid/ready holding register.
// Define DESER_TIMEOUT_EN to discard partial words after TIMEOUT idle cycles (pulses frame_err).
module deserializer #(
  parameter int unsigned L       = 128,
  parameter int unsigned TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  deserializer_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(L);
  localparam logic [CntW-1:0] CntLast = CntW'(L - 1);

  if (L < 2) begin : gen_bad_l
    $error("deserializer: L must be at least 2");
  end
  if (TIMEOUT < 1) begin : gen_bad_timeout
    $error("deserializer: TIMEOUT must be at least 1");
  end

  // Only L-1 bits need storing; the L-th bit goes straight into the word.
  logic [L-2:0]    sr_q, sr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [L-1:0]    q_q, q_d;
  logic            qvalid_q, qvalid_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      dropped_q, dropped_d;
  logic [L-1:0]    shifted;

`ifdef DESER_TIMEOUT_EN
  localparam int unsigned     IdleW    = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             frame_err_q, frame_err_d;
`endif

  assign shifted = {sr_q, bus.qbit};

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    qvalid_d  = qvalid_q;
    overrun_d = overrun_q;
    dropped_d = dropped_q;

    if (qvalid_q && bus.qready) begin
      qvalid_d = 1'b0;
    end

    if (bus.qbiten) begin
      sr_d = shifted[L-2:0];
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        // A same-edge consume frees the holding register for the new word.
        if (!qvalid_q || bus.qready) begin
          q_d      = shifted;
          qvalid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
          if (dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

`ifdef DESER_TIMEOUT_EN
    idle_d      = idle_q;
    frame_err_d = 1'b0;
    if (bus.qbiten) begin
      idle_d = '0;
    end else if (cnt_q != '0) begin
      if (idle_q == IdleLast) begin
        cnt_d       = '0;
        idle_d      = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      qvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      qvalid_q  <= qvalid_d;
      overrun_q <= overrun_d;
      dropped_q <= dropped_d;
    end
  end

`ifdef DESER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.q       = q_q;
  assign bus.qvalid  = qvalid_q;
  assign bus.overrun = overrun_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed, self-checking bench for deserializer (L=128, TIMEOUT=16).
module tb_deserializer;

  localparam int unsigned L = 128;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  deserializer_if #(.L(L)) bus ();

  deserializer #(
    .L      (L),
    .TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string        name;
    logic [127:0] word;
    bit           gapped;
    logic [127:0] exp_q;
  } vec_t;

  localparam logic [127:0] W0   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] W1   = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
  localparam logic [127:0] W2   = 128'h5555AAAA_0F0F0F0F_00000000_FFFF0001;
  localparam logic [127:0] ONES = {128{1'b1}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Send bits [from, from+n) of w, MSB first; gapped inserts one idle cycle after each bit.
  task automatic send_bits(input logic [127:0] w, input int from, input int n, input bit gapped);
    for (int k = from; k < from + n; k++) begin
      bus.qbiten = 1'b1;
      bus.qbit   = w[127-k];
      tick();
      if (gapped) begin
        bus.qbiten = 1'b0;
        tick();
      end
    end
    bus.qbiten = 1'b0;
  endtask

  task automatic consume();
    bus.qready = 1'b1;
    tick();
    bus.qready = 1'b0;
  endtask

  vec_t vecs[4];
  int   fe_pulses;

  initial begin
    reset      = 1'b0;
    bus.qbit   = 1'b0;
    bus.qbiten = 1'b0;
    bus.qready = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    check("rst_q", bus.q, 128'h0);
    check("rst_qvalid", bus.qvalid, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_dropped", bus.dropped, 0);
    check("rst_frame_err", bus.frame_err, 0);

    vecs[0] = '{"w0_contig", W0, 1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210};
    vecs[1] = '{"w0_gapped", W0, 1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210};
    vecs[2] = '{"ones",      ONES, 1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF};
    vecs[3] = '{"w2_gapped", W2, 1'b1, 128'h5555AAAA_0F0F0F0F_00000000_FFFF0001};

    foreach (vecs[i]) begin
      do_reset();
      send_bits(vecs[i].word, 0, 127, vecs[i].gapped);
      check({vecs[i].name, "_pre_qvalid"}, bus.qvalid, 0);
      send_bits(vecs[i].word, 127, 1, 1'b0);
      check({vecs[i].name, "_qvalid"}, bus.qvalid, 1);
      check({vecs[i].name, "_q"}, bus.q, vecs[i].exp_q);
      check({vecs[i].name, "_overrun"}, bus.overrun, 0);
      consume();
      check({vecs[i].name, "_consumed"}, bus.qvalid, 0);
      check({vecs[i].name, "_q_hold"}, bus.q, vecs[i].exp_q);
    end

    // Back-to-back with no consumer: first word held, later words dropped.
    do_reset();
    send_bits(W0, 0, 128, 1'b0);
    send_bits(W1, 0, 128, 1'b0);
    check("ovr_q", bus.q, W0);
    check("ovr_qvalid", bus.qvalid, 1);
    check("ovr_overrun", bus.overrun, 1);
    check("ovr_dropped1", bus.dropped, 1);
    send_bits(W2, 0, 128, 1'b0);
    check("ovr_dropped2", bus.dropped, 2);
    consume();
    check("ovr_consumed", bus.qvalid, 0);
    check("ovr_sticky", bus.overrun, 1);

    // Consume on the same edge as the second completion: no drop.
    do_reset();
    send_bits(W0, 0, 128, 1'b0);
    send_bits(W1, 0, 127, 1'b0);
    check("same_pre_q", bus.q, W0);
    bus.qbiten = 1'b1;
    bus.qbit   = W1[0];
    bus.qready = 1'b1;
    tick();
    bus.qbiten = 1'b0;
    bus.qready = 1'b0;
    check("same_q", bus.q, W1);
    check("same_qvalid", bus.qvalid, 1);
    check("same_dropped", bus.dropped, 0);
    check("same_overrun", bus.overrun, 0);

    // Reset mid-word must discard the partial word.
    do_reset();
    send_bits(W0, 0, 50, 1'b0);
    do_reset();
    check("midrst_qvalid", bus.qvalid, 0);
    check("midrst_q", bus.q, 128'h0);
    send_bits(ONES, 0, 127, 1'b0);
    check("midrst_pre_qvalid", bus.qvalid, 0);
    send_bits(ONES, 127, 1, 1'b0);
    check("midrst_qvalid_end", bus.qvalid, 1);
    check("midrst_q_ones", bus.q, ONES);

    // Partial word followed by a long idle gap.
    do_reset();
    send_bits(W0, 0, 10, 1'b0);
    fe_pulses = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.frame_err) fe_pulses++;
`ifdef DESER_TIMEOUT_EN
      if (c == 15) check("to_fe_on_16th", bus.frame_err, 1);
`endif
    end
    tick();
    check("to_fe_one_cycle", bus.frame_err, 0);
`ifdef DESER_TIMEOUT_EN
    check("to_fe_pulses", fe_pulses, 1);
    send_bits(W1, 0, 127, 1'b0);
    check("to_pre_qvalid", bus.qvalid, 0);
    send_bits(W1, 127, 1, 1'b0);
    check("to_qvalid", bus.qvalid, 1);
    check("to_q", bus.q, W1);
`else
    check("to_fe_pulses", fe_pulses, 0);
    check("to_idle_qvalid", bus.qvalid, 0);
    send_bits(W0, 10, 118, 1'b0);
    check("to_qvalid", bus.qvalid, 1);
    check("to_q", bus.q, W0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the output serializer. Collects the one-bit-per-cycle stream (`qbit` qualified by `qbiten`) back into L-bit extractor words and presents each word on a one-deep valid/ready output. Sits at the far end of the serial link from the Toeplitz extractor, feeding the downstream consumer or checker.

## Interface

- `L`, 128, word length in bits; must equal the extractor output width; L ≥ 2.
- `TIMEOUT`, 16, idle-cycle limit for partial-word discard; used only with `DESER_TIMEOUT_EN`; TIMEOUT ≥ 1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `qbit`  in  1  serial data bit.
- `qbiten`  in  1  `qbit` is valid this cycle.
- `q`  out  L  assembled word; stable while `qvalid`=1.
- `qvalid`  out  1  `q` holds an unconsumed word.
- `qready`  in  1  consumer accepts `q` on an edge where `qvalid`=1 and `qready`=1.
- `overrun`  out  1  sticky; a completed word was dropped.
- `dropped`  out  8  count of dropped words; saturates at 255.
- `frame_err`  out  1  one-cycle pulse; a partial word was discarded by timeout.

## Operation

- Bit order: MSB first. The first accepted bit of a word lands in `q[L-1]`, the L-th in `q[0]`.
- Shift register `sr[L-1:0]` and bit counter `cnt` (0..L-1, width $clog2(L)).
- On an edge with `qbiten`=1: `sr <= {sr[L-2:0], qbit}`. If `cnt`=L-1, the word is complete and `cnt` wraps to 0. Otherwise `cnt` increments.
- Completion, when `cnt`=L-1 and `qbiten`=1:
  - If the holding register is empty, or is consumed on this same edge (`qvalid`&`qready`), then `q <= {sr[L-2:0], qbit}` and `qvalid` stays or becomes 1.
  - Otherwise the new word is dropped. `q` keeps the old word, `overrun` is set to 1, and `dropped` increments, saturating at 255.
- Consume: `qvalid`&`qready` with no simultaneous completion gives `qvalid` <= 0.
- `qbiten`=0 leaves `sr` and `cnt` unchanged. With the timeout feature disabled, there is no limit on the gap between bits.
- `overrun` and `dropped` clear only on reset.
- `qready` is ignored while `qvalid`=0.

## Timing

- Reset, on an edge with `reset`=0: `q`=0, `qvalid`=0, `overrun`=0, `dropped`=0, `frame_err`=0, `cnt`=0, `sr`=0, timeout counter=0. Any in-flight partial word and any held word are discarded.
- Reset asserted on the same edge as a completion or consume: reset wins.
- Latency: the L-th bit is sampled at edge k, and `qvalid`=1 with the full `q` is visible after edge k. There is no extra pipeline stage.
- Back-to-back words with no gaps are supported. The consumer must assert `qready` within L cycles of `qvalid` to avoid overrun.
- Consume and completion on the same edge: new word is loaded, `qvalid` stays 1, no drop.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration

- `DESER_TIMEOUT_EN` defined:
  - An idle counter counts consecutive cycles with `qbiten`=0 while `cnt`≠0. Any accepted bit clears it.
  - When the counter reaches TIMEOUT, on that edge: `cnt` <= 0, idle counter <= 0, and `frame_err` pulses 1 for exactly one cycle. `sr` contents become don't-care.
  - Idle time with `cnt`=0 never triggers a timeout.
- `DESER_TIMEOUT_EN` undefined:
  - No idle counter is built. `frame_err` is tied to 0.
  - A partial word waits indefinitely.
  - The port list is identical in both builds.

## Test plan

- Reset, then 128 consecutive bits of word `0x0123456789ABCDEF_FEDCBA9876543210` MSB-first, with `qready`=1 -> `qvalid` rises after the 128th bit edge, `q` equals the word, `overrun`=0.
- Same word sent with `qbiten` toggling 1/0 each cycle (256 cycles) -> identical `q`. `qvalid` rises only after the 128th accepted bit.
- Two words back-to-back with `qready`=0 throughout -> first word held in `q`, `overrun`=1, `dropped`=1. Then pulse `qready` -> `qvalid`=0.
- Two words back-to-back with `qready` asserted exactly on the second word's completion edge -> second word loaded, `qvalid` stays 1, `dropped`=0.
- Send 50 bits, assert `reset`=0 for one cycle, then send a full word `0xFFFF...FFFF` -> `q`=all ones. No stale bits appear, and `qvalid` was 0 after reset.
- With `DESER_TIMEOUT_EN`: send 10 bits, idle 16 cycles -> `frame_err` pulses once, `cnt`=0. The next 128 bits form a correct word. Without the macro, the same stimulus gives `frame_err`=0, and the next 118 bits complete a word.
